// File: rtl/mini_cpu_pkg.sv
// mini_cpu_pkg: shared widths, register address type and regfile state encoding for the mini CPU.
package mini_cpu_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } rf_state_e;
endpackage

// File: rtl/mini_cpu_regfile_if.sv
// mini_cpu_regfile_if: operand fetch/store bus between the control unit (master) and the register file (slave).
interface mini_cpu_regfile_if;
    import mini_cpu_pkg::*;

    logic      rd_en;
    reg_addr_t rd_addr_a;
    reg_addr_t rd_addr_b;
    data_t     rd_data_a;
    data_t     rd_data_b;
    logic      rd_valid;
    logic      wr_en;
    reg_addr_t wr_addr;
    data_t     wr_data;
    logic      clr_req;
    logic      busy;
    reg_addr_t dbg_addr;
    data_t     dbg_data;

    modport master (
        output rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, clr_req, dbg_addr,
        input  rd_data_a, rd_data_b, rd_valid, busy, dbg_data
    );

    modport slave (
        input  rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, clr_req, dbg_addr,
        output rd_data_a, rd_data_b, rd_valid, busy, dbg_data
    );
endinterface

// File: rtl/mini_cpu_rf_clear_seq.sv
// mini_cpu_rf_clear_seq: clear sequencer; sweeps every register to zero after reset or on request.
module mini_cpu_rf_clear_seq
    import mini_cpu_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      clr_req_i,
    output logic      clr_we_o,
    output reg_addr_t clr_addr_o,
    output logic      busy_o
);
    rf_state_e state_q, state_d;
    reg_addr_t clr_cnt_q, clr_cnt_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // clr_cnt wraps to 0 on its own as the last entry is written
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == S_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == reg_addr_t'(DEPTH - 1)) state_d = S_READY;
        end else if (clr_req_i) begin
            state_d   = S_CLEAR;
            clr_cnt_d = '0;
        end
    end

    assign clr_we_o   = (state_q == S_CLEAR);
    assign clr_addr_o = clr_cnt_q;
    assign busy_o     = (state_q == S_CLEAR);
endmodule

// File: rtl/mini_cpu_regfile.sv
// mini_cpu_regfile: 2R1W register file with clear sequencer and debug port.
// Define MINI_CPU_RF_BYPASS_EN for write-first read ports; default is read-first.
module mini_cpu_regfile
    import mini_cpu_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    mini_cpu_regfile_if.slave        rf
);
    logic      busy, clr_we, rd_fire, wr_fire;
    reg_addr_t clr_addr;
    data_t     mem_q [DEPTH];
    data_t     rd_a_val, rd_b_val;
    data_t     rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d, dbg_data_q;
    logic      rd_valid_q;

    mini_cpu_rf_clear_seq u_clear_seq (
        .clk        (clk),
        .reset      (reset),
        .clr_req_i  (rf.clr_req),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .busy_o     (busy)
    );

    assign rd_fire = rf.rd_en & ~busy;
    assign wr_fire = rf.wr_en & ~busy & ~rf.clr_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            if (clr_we) mem_q[clr_addr] <= '0;
            else if (wr_fire) mem_q[rf.wr_addr] <= rf.wr_data;
        end
    end

`ifdef MINI_CPU_RF_BYPASS_EN
    assign rd_a_val = (wr_fire && rf.wr_addr == rf.rd_addr_a) ? rf.wr_data : mem_q[rf.rd_addr_a];
    assign rd_b_val = (wr_fire && rf.wr_addr == rf.rd_addr_b) ? rf.wr_data : mem_q[rf.rd_addr_b];
`else
    assign rd_a_val = mem_q[rf.rd_addr_a];
    assign rd_b_val = mem_q[rf.rd_addr_b];
`endif

    assign rd_data_a_d = rd_fire ? rd_a_val : rd_data_a_q;
    assign rd_data_b_d = rd_fire ? rd_b_val : rd_data_b_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
            rd_valid_q  <= 1'b0;
            dbg_data_q  <= '0;
        end else begin
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
            rd_valid_q  <= rd_fire;
            dbg_data_q  <= mem_q[rf.dbg_addr];
        end
    end

    assign rf.rd_data_a = rd_data_a_q;
    assign rf.rd_data_b = rd_data_b_q;
    assign rf.rd_valid  = rd_valid_q;
    assign rf.busy      = busy;
    assign rf.dbg_data  = dbg_data_q;
endmodule

// File: tb/tb_mini_cpu_regfile.sv
// tb_mini_cpu_regfile: directed checks of clear, read/write, collision, clear request and debug port.
module tb_mini_cpu_regfile;
    import mini_cpu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    int n;

    mini_cpu_regfile_if rf ();

    mini_cpu_regfile dut (
        .clk   (clk),
        .reset (reset),
        .rf    (rf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rf.rd_en = 0; rf.wr_en = 0; rf.clr_req = 0;
    endtask

    task automatic wr(input reg_addr_t a, input data_t d);
        rf.wr_en = 1; rf.wr_addr = a; rf.wr_data = d;
        tick();
        rf.wr_en = 0;
    endtask

    task automatic rd(input reg_addr_t a, input reg_addr_t b);
        rf.rd_en = 1; rf.rd_addr_a = a; rf.rd_addr_b = b;
        tick();
        rf.rd_en = 0;
    endtask

    task automatic wait_clear(input string tag);
        n = 0;
        while (rf.busy && n < 40) begin
            tick();
            n++;
        end
        chk(tag, n, 16);
    endtask

    task automatic all_zero(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            rd(reg_addr_t'(i), reg_addr_t'(DEPTH - 1 - i));
            chk({tag, "_valid"}, rf.rd_valid, 1);
            chk({tag, "_a"}, rf.rd_data_a, 0);
            chk({tag, "_b"}, rf.rd_data_b, 0);
        end
    endtask

    initial begin
        idle();
        rf.rd_addr_a = 0; rf.rd_addr_b = 0; rf.wr_addr = 0; rf.wr_data = 0; rf.dbg_addr = 0;
        // 1: reset and initial clear
        tick(); tick();
        chk("rst_busy", rf.busy, 1);
        chk("rst_valid", rf.rd_valid, 0);
        chk("rst_rda", rf.rd_data_a, 0);
        chk("rst_rdb", rf.rd_data_b, 0);
        chk("rst_dbg", rf.dbg_data, 0);
        reset = 1;
        wait_clear("init_busy_len");
        all_zero("init_zero");
        // 2: write then read
        wr(3, 16'h00A5);
        rd(3, 0);
        chk("t2_a", rf.rd_data_a, 16'h00A5);
        chk("t2_b", rf.rd_data_b, 16'h0000);
        chk("t2_valid", rf.rd_valid, 1);
        tick();
        chk("t2_pulse", rf.rd_valid, 0);
        chk("t2_hold", rf.rd_data_a, 16'h00A5);
        // 3: same-cycle read and write
        wr(7, 16'h0001);
        rf.wr_en = 1; rf.wr_addr = 7; rf.wr_data = 16'h1234;
        rd(7, 3);
        rf.wr_en = 0;
`ifdef MINI_CPU_RF_BYPASS_EN
        chk("t3_coll_a", rf.rd_data_a, 16'h1234);
`else
        chk("t3_coll_a", rf.rd_data_a, 16'h0001);
`endif
        chk("t3_coll_b", rf.rd_data_b, 16'h00A5);
        rd(3, 7);
        chk("t3_after", rf.rd_data_b, 16'h1234);
        // 4: clear request with simultaneous write; traffic during busy is dropped
        wr(5, 16'hBEEF);
        rf.clr_req = 1; rf.wr_en = 1; rf.wr_addr = 6; rf.wr_data = 16'h0042;
        tick();
        chk("t4_busy", rf.busy, 1);
        n = 0;
        rf.wr_addr = 5; rf.wr_data = 16'h1111;
        while (rf.busy && n < 40) begin
            rf.rd_en = 1; rf.rd_addr_a = 5; rf.wr_en = 1;
            rf.clr_req = (n < 4);
            tick();
            n++;
            chk("t4_no_valid", rf.rd_valid, 0);
        end
        idle();
        chk("t4_busy_len", n, 16);
        rd(5, 6);
        chk("t4_r5", rf.rd_data_a, 0);
        chk("t4_r6", rf.rd_data_b, 0);
        // 5: reset in the middle of a clear restarts it
        wr(9, 16'h5A5A);
        rf.clr_req = 1;
        tick();
        rf.clr_req = 0;
        repeat (8) tick();
        chk("t5_mid_busy", rf.busy, 1);
        reset = 0;
        tick();
        chk("t5_rst_busy", rf.busy, 1);
        chk("t5_rst_valid", rf.rd_valid, 0);
        reset = 1;
        wait_clear("t5_busy_len");
        all_zero("t5_zero");
        // 6: debug port and same address on both ports
        wr(15, 16'hFFFF);
        rf.dbg_addr = 15;
        tick();
        chk("t6_dbg", rf.dbg_data, 16'hFFFF);
        rf.dbg_addr = 3;
        tick();
        chk("t6_dbg_clr", rf.dbg_data, 0);
        rd(15, 15);
        chk("t6_a", rf.rd_data_a, 16'hFFFF);
        chk("t6_b", rf.rd_data_b, 16'hFFFF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
